// File: rtl/row_ram_uart_reader_if.sv
// Control and RAM read-port bundle between a row controller/row RAM and the UART row reader.
`timescale 1ns/1ps
interface row_ram_uart_reader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [ADDR_W-1:0] addr_out;
    logic [7:0]        ram_dout;
    logic              busy;
    logic              row_done;

    // The reader drives the address and status; the controller/RAM side drives start and read data.
    modport master (
        input  start,
        input  ram_dout,
        output addr_out,
        output busy,
        output row_done
    );

    modport slave (
        output start,
        output ram_dout,
        input  addr_out,
        input  busy,
        input  row_done
    );
endinterface

// File: rtl/row_ram_uart_reader.sv
// Drains one row of bytes from a synchronous row RAM and sends each byte as a UART 8N1 frame.
`timescale 1ns/1ps
module row_ram_uart_reader #(
    parameter int ROW_LEN  = 480,
    parameter int ADDR_W   = 9,
    parameter int BAUD_DIV = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    row_ram_uart_reader_if.master   bus,
    output logic                    uart_tx
);

    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROW_LEN - 1);
    localparam logic [3:0]        SLOT_STOP = 4'd9;
    localparam logic [3:0]        SLOT_LAST_DATA = 4'd8;

    typedef enum logic [2:0] {IDLE, RD, LATCH, TX, DONE} state_t;

    state_t            state, state_nx;
    logic [BAUD_W-1:0] baud_cnt, baud_nx;
    logic [3:0]        bit_cnt, bit_nx;
    logic [7:0]        shift_q, shift_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              tx_q, tx_nx;
    logic              busy_q, busy_nx;
    logic              done_q, done_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            addr_q   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_cnt  <= bit_nx;
            shift_q  <= shift_nx;
            addr_q   <= addr_nx;
            tx_q     <= tx_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
        end
    end

    // Outputs are registered: each next value is what the line/status should show after the edge.
    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_cnt;
        shift_nx = shift_q;
        addr_nx  = addr_q;
        tx_nx    = tx_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (bus.start) begin
                    state_nx = RD;
                    addr_nx  = '0;
                    busy_nx  = 1'b1;
                end
            end
            RD: begin
                state_nx = LATCH;
            end
            LATCH: begin
                shift_nx = bus.ram_dout;
                baud_nx  = '0;
                bit_nx   = '0;
                tx_nx    = 1'b0;
                state_nx = TX;
            end
            TX: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nx = '0;
                    if (bit_cnt == SLOT_STOP) begin
                        if (addr_q == ADDR_LAST) begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                            addr_nx  = '0;
                        end else begin
                            state_nx = RD;
                            addr_nx  = addr_q + ADDR_W'(1);
                        end
                    end else begin
                        // bit_cnt is the slot just finishing, so slot n+1 carries data bit n
                        bit_nx = bit_cnt + 4'd1;
                        tx_nx  = (bit_cnt == SLOT_LAST_DATA) ? 1'b1 : shift_q[bit_cnt[2:0]];
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
            DONE: begin
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.addr_out = addr_q;
    assign bus.busy     = busy_q;
    assign bus.row_done = done_q;
    assign uart_tx      = tx_q;

endmodule

// File: tb/tb_row_ram_uart_reader.sv
// Directed bench for row_ram_uart_reader: three instances cover a short row, the default row and BAUD_DIV=2.
`timescale 1ns/1ps
module tb_row_ram_uart_reader;

    logic clk = 1'b0;
    logic rst_n;
    logic txA, txB, txC;

    row_ram_uart_reader_if #(.ADDR_W(9)) busA();
    row_ram_uart_reader_if #(.ADDR_W(9)) busB();
    row_ram_uart_reader_if #(.ADDR_W(9)) busC();

    row_ram_uart_reader #(.ROW_LEN(4), .ADDR_W(9), .BAUD_DIV(10)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA), .uart_tx(txA));
    row_ram_uart_reader #(.ROW_LEN(480), .ADDR_W(9), .BAUD_DIV(10)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB), .uart_tx(txB));
    row_ram_uart_reader #(.ROW_LEN(1), .ADDR_W(9), .BAUD_DIV(2)) dutC (
        .clk(clk), .rst_n(rst_n), .bus(busC), .uart_tx(txC));

    always #5 clk = ~clk;

    logic [7:0] memA [0:3];
    initial begin
        memA[0] = 8'h00; memA[1] = 8'h55; memA[2] = 8'hA5; memA[3] = 8'hFF;
    end

    always @(posedge clk) begin
        busA.ram_dout <= memA[busA.addr_out[1:0]];
        busB.ram_dout <= busB.addr_out[7:0];
        busC.ram_dout <= 8'h80;
    end

    int nChecks = 0;
    int nFail   = 0;
    int rstEpoch = 0;

    logic [7:0] qa[$], qb[$], qc[$];
    int frameErrA = 0, frameErrB = 0, frameErrC = 0;

    function automatic logic getTx(input int sel);
        case (sel)
            0: return txA;
            1: return txB;
            default: return txC;
        endcase
    endfunction

    function automatic logic getBusy(input int sel);
        case (sel)
            0: return busA.busy;
            1: return busB.busy;
            default: return busC.busy;
        endcase
    endfunction

    function automatic logic getDone(input int sel);
        case (sel)
            0: return busA.row_done;
            1: return busB.row_done;
            default: return busC.row_done;
        endcase
    endfunction

    function automatic logic [8:0] getAddr(input int sel);
        case (sel)
            0: return busA.addr_out;
            1: return busB.addr_out;
            default: return busC.addr_out;
        endcase
    endfunction

    task automatic applyStimulus(input int sel, input logic val);
        case (sel)
            0: busA.start = val;
            1: busB.start = val;
            default: busC.start = val;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Line decoder: samples mid-slot on falling clock edges and drops any frame cut by reset.
    task automatic rxFrame(input int sel, input int div, output logic [7:0] data,
                           output bit ok, output bit aborted);
        logic [9:0] bits;
        int ep;
        bits = '0;
        aborted = 1'b0;
        @(negedge clk);
        while (!(rst_n === 1'b1 && getTx(sel) === 1'b0)) @(negedge clk);
        ep = rstEpoch;
        for (int s = 0; s < 10 && !aborted; s++) begin
            for (int w = 0; w < ((s == 0) ? div / 2 : div) && !aborted; w++) begin
                @(negedge clk);
                if (rstEpoch != ep || rst_n !== 1'b1) aborted = 1'b1;
            end
            if (!aborted) bits[s] = getTx(sel);
        end
        data = bits[8:1];
        ok = (bits[0] == 1'b0) && (bits[9] == 1'b1);
    endtask

    initial begin
        logic [7:0] d; bit ok, ab;
        forever begin
            rxFrame(0, 10, d, ok, ab);
            if (!ab) begin qa.push_back(d); if (!ok) frameErrA++; end
        end
    end

    initial begin
        logic [7:0] d; bit ok, ab;
        forever begin
            rxFrame(1, 10, d, ok, ab);
            if (!ab) begin qb.push_back(d); if (!ok) frameErrB++; end
        end
    end

    initial begin
        logic [7:0] d; bit ok, ab;
        forever begin
            rxFrame(2, 2, d, ok, ab);
            if (!ab) begin qc.push_back(d); if (!ok) frameErrC++; end
        end
    end

    int firstLow, doneAt, doneCount, stepErr, maxAddr;
    logic busyAtK;
    logic [8:0] addrAtK;
    logic [63:0] lineBits;

    // Pulse start so edge k samples it, then watch for `limit` cycles; c counts edges after k.
    task automatic runRow(input int sel, input int limit, input int p1, input int p2);
        logic [8:0] prevAddr, a;
        firstLow = -1; doneAt = -1; doneCount = 0; stepErr = 0; maxAddr = 0;
        lineBits = '0;
        applyStimulus(sel, 1'b1);
        @(posedge clk); #1;
        applyStimulus(sel, 1'b0);
        busyAtK  = getBusy(sel);
        addrAtK  = getAddr(sel);
        lineBits[0] = getTx(sel);
        prevAddr = addrAtK;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            applyStimulus(sel, (c == p1 || c == p2));
            if (c < 64) lineBits[c] = getTx(sel);
            if (firstLow < 0 && getTx(sel) === 1'b0) firstLow = c;
            if (getDone(sel) === 1'b1) begin
                doneCount++;
                if (doneAt < 0) doneAt = c;
            end
            a = getAddr(sel);
            if (a != prevAddr) begin
                if (!(a == prevAddr + 9'd1 || (a == 9'd0 && getDone(sel) === 1'b1))) stepErr++;
            end
            if (int'(a) > maxAddr) maxAddr = int'(a);
            prevAddr = a;
        end
    endtask

    initial begin
        int idleErr, byteErr;
        busA.start = 1'b0; busB.start = 1'b0; busC.start = 1'b0;
        rst_n = 1'b0;
        #22;
        checkOutput("reset uart_tx", 64'(txA), 64'd1);
        checkOutput("reset busy", 64'(busA.busy), 64'd0);
        checkOutput("reset addr_out", 64'(busA.addr_out), 64'd0);
        checkOutput("reset row_done", 64'(busA.row_done), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        idleErr = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (txA !== 1'b1 || busA.busy !== 1'b0 || busA.addr_out !== 9'd0 || busA.row_done !== 1'b0)
                idleErr++;
        end
        checkOutput("idle violations", 64'(idleErr), 64'd0);

        $display("[TB] short row");
        qa.delete();
        runRow(0, 412, -1, -1);
        checkOutput("short busy at k", 64'(busyAtK), 64'd1);
        checkOutput("short addr at k", 64'(addrAtK), 64'd0);
        checkOutput("short first low", 64'(firstLow), 64'd2);
        checkOutput("short row_done edge", 64'(doneAt), 64'd408);
        checkOutput("short row_done count", 64'(doneCount), 64'd1);
        checkOutput("short addr steps", 64'(stepErr), 64'd0);
        checkOutput("short byte count", 64'(qa.size()), 64'd4);
        if (qa.size() == 4) begin
            checkOutput("short byte0", 64'(qa[0]), 64'h00);
            checkOutput("short byte1", 64'(qa[1]), 64'h55);
            checkOutput("short byte2", 64'(qa[2]), 64'hA5);
            checkOutput("short byte3", 64'(qa[3]), 64'hFF);
        end
        checkOutput("short frame errors", 64'(frameErrA), 64'd0);
        checkOutput("short busy after", 64'(busA.busy), 64'd0);
        checkOutput("short addr after", 64'(busA.addr_out), 64'd0);

        $display("[TB] default row");
        qb.delete();
        runRow(1, 48964, -1, -1);
        checkOutput("default row_done edge", 64'(doneAt), 64'd48960);
        checkOutput("default row_done count", 64'(doneCount), 64'd1);
        checkOutput("default max addr", 64'(maxAddr), 64'd479);
        checkOutput("default addr steps", 64'(stepErr), 64'd0);
        checkOutput("default byte count", 64'(qb.size()), 64'd480);
        byteErr = 0;
        for (int i = 0; i < qb.size(); i++) if (qb[i] !== 8'(i)) byteErr++;
        checkOutput("default byte values", 64'(byteErr), 64'd0);
        if (qb.size() > 0) checkOutput("default last byte", 64'(qb[qb.size()-1]), 64'hDF);
        checkOutput("default frame errors", 64'(frameErrB), 64'd0);
        checkOutput("default busy after", 64'(busB.busy), 64'd0);
        checkOutput("default addr after", 64'(busB.addr_out), 64'd0);

        $display("[TB] start while busy");
        qa.delete();
        runRow(0, 409, 130, 408);
        checkOutput("busy-start row_done edge", 64'(doneAt), 64'd408);
        checkOutput("busy-start row_done count", 64'(doneCount), 64'd1);
        checkOutput("busy-start byte count", 64'(qa.size()), 64'd4);
        checkOutput("busy-start idle after", 64'(busA.busy), 64'd0);
        qa.delete();
        runRow(0, 412, -1, -1);
        checkOutput("restart busy at k", 64'(busyAtK), 64'd1);
        checkOutput("restart addr at k", 64'(addrAtK), 64'd0);
        checkOutput("restart first low", 64'(firstLow), 64'd2);
        checkOutput("restart row_done edge", 64'(doneAt), 64'd408);
        checkOutput("restart byte count", 64'(qa.size()), 64'd4);

        $display("[TB] reset mid-frame");
        qa.delete();
        runRow(0, 250, -1, -1);
        rstEpoch++;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset uart_tx", 64'(txA), 64'd1);
        checkOutput("midreset busy", 64'(busA.busy), 64'd0);
        checkOutput("midreset addr_out", 64'(busA.addr_out), 64'd0);
        checkOutput("midreset row_done", 64'(busA.row_done), 64'd0);
        checkOutput("midreset bytes before", 64'(qa.size()), 64'd2);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        qa.delete();
        runRow(0, 412, -1, -1);
        checkOutput("resend row_done edge", 64'(doneAt), 64'd408);
        checkOutput("resend byte count", 64'(qa.size()), 64'd4);
        if (qa.size() > 1) begin
            checkOutput("resend byte0", 64'(qa[0]), 64'h00);
            checkOutput("resend byte1", 64'(qa[1]), 64'h55);
        end

        $display("[TB] baud edge case");
        qc.delete();
        runRow(2, 26, -1, -1);
        checkOutput("baud2 first low", 64'(firstLow), 64'd2);
        checkOutput("baud2 row_done edge", 64'(doneAt), 64'd22);
        checkOutput("baud2 row_done count", 64'(doneCount), 64'd1);
        checkOutput("baud2 line pattern", 64'(lineBits[21:0]), 64'h3C0003);
        checkOutput("baud2 byte count", 64'(qc.size()), 64'd1);
        if (qc.size() == 1) checkOutput("baud2 byte", 64'(qc[0]), 64'h80);
        checkOutput("baud2 frame errors", 64'(frameErrC), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/row_ram_uart_reader.md
# row_ram_uart_reader

Reads one row of pixel bytes out of the row RAM read port and serialises them on a UART 8N1 line, one byte per frame, addresses 0 to ROW_LEN-1 in order. It is the read-side counterpart of the UART-to-row-RAM write path: the writer fills the row RAM from `uart_rx`, and this block drains the same RAM back out on `uart_tx`. It pulses `row_done` when the last stop bit has finished, so a controller can start the next row.

## Interface
- `ROW_LEN`, default 480: bytes per row; legal range 1 to 2^ADDR_W.
- `ADDR_W`, default 9: width of the RAM address.
- `BAUD_DIV`, default 10: clock cycles per UART bit; minimum 2.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request to send one row; sampled only in IDLE.
- `ram_dout`  in  8  RAM read data; synchronous RAM, valid one cycle after `addr_out`.
- `addr_out`  out  ADDR_W  RAM read address (registered).
- `uart_tx`  out  1  serial output; idles high (registered).
- `busy`  out  1  high from the cycle after `start` is accepted until `row_done`.
- `row_done`  out  1  one-cycle pulse after the last byte's stop bit.

## Operation
- Reset values:
  - `addr_out`=0, `uart_tx`=1, `busy`=0, `row_done`=0.
  - State is IDLE; bit counter, baud counter and shift register are all 0.
- States: IDLE, RD, LATCH, TX, DONE.
  - **IDLE**: if `start`=1, go to RD with `addr_out`=0 and `busy`=1. Otherwise stay.
  - **RD**: `addr_out` is stable for one cycle while the RAM read completes. Go to LATCH.
  - **LATCH**: capture `ram_dout` into the 8-bit shift register. Clear the bit counter and baud counter. Go to TX.
  - **TX**: send 10 bit slots, each exactly BAUD_DIV cycles:
    - slot 0: start bit, 0.
    - slots 1–8: data bits, LSB first.
    - slot 9: stop bit, 1.
  - **TX, end of stop slot**:
    - If `addr_out`==ROW_LEN-1, go to DONE.
    - Otherwise `addr_out`+1 and go to RD.
  - **DONE**: `row_done`=1 for one cycle, `busy`=0, `addr_out`=0, then go to IDLE.
- `uart_tx` is 1 in IDLE, RD, LATCH and DONE. The line stays high between bytes, which lengthens the stop bit by 2 cycles.
- `start` is ignored outside IDLE; no queuing.
- Counters:
  - Baud counter runs 0 to BAUD_DIV-1 and wraps.
  - Bit counter runs 0 to 9 and advances when the baud counter wraps.
  - `addr_out` never exceeds ROW_LEN-1, and never wraps past 2^ADDR_W.
- Reset asserted at any point, including mid-bit: all outputs return to their reset values immediately. A partial frame is abandoned and is not resumed.

## Timing
- Reference point: `start` is high at rising edge k, in IDLE.
- Edge k:
  - `busy`=1, `addr_out`=0, state RD.
- Edge k+1:
  - state LATCH.
  - RAM presents byte 0 by edge k+2.
- Edge k+2:
  - shift register loaded, state TX, `uart_tx` goes to 0 (start bit).
- Data bit n is driven from edge k+2+(n+1)·BAUD_DIV.
- Stop bit is driven from edge k+2+9·BAUD_DIV.
- Period from one start bit to the next is 10·BAUD_DIV+2 cycles.
- Final stop bit ends at edge k+ROW_LEN·(10·BAUD_DIV+2). On that edge the block enters DONE and `row_done`=1 for one cycle.
- On the next edge, `busy`=0 and the block is in IDLE.
- `start` asserted in the same cycle that `row_done` is high is ignored, because the block is in DONE. The earliest accepted restart is `start` high in the following cycle.

## Test plan
- **Short row**: ROW_LEN=4, BAUD_DIV=10, RAM = 0x00, 0x55, 0xA5, 0xFF; pulse `start`.
  - The bench decoder recovers the same 4 bytes in order.
  - Each frame is 0 start, 8 data LSB first, 1 stop.
  - First falling edge of `uart_tx` is 2 cycles after `start`.
  - `row_done` pulses exactly once at edge k+408.
- **Default row**: ROW_LEN=480, RAM[i]=i[7:0].
  - `addr_out` steps 0 to 479; 480 bytes are decoded, ending 0xDF.
  - `row_done` pulses once; afterwards `addr_out`=0 and `busy`=0.
- **Start while busy**: pulse `start` during byte 1's data slot and again on the `row_done` cycle.
  - Neither pulse restarts the block and no extra byte is sent.
  - A `start` one cycle after `row_done` begins a new row at address 0.
- **Reset mid-frame**: assert `rst_n`=0 in the data-bit-3 slot of byte 2.
  - `uart_tx`=1, `busy`=0, `addr_out`=0 immediately.
  - After release and a new `start`, the row resends from byte 0.
- **Baud edge case**: BAUD_DIV=2, ROW_LEN=1, RAM[0]=0x80.
  - Line reads 0, then 0 ×7, then 1, then stop 1, each slot 2 cycles.
  - `row_done` pulses at edge k+22.
- **Idle check**: with no `start` for 1000 cycles after reset, `uart_tx` stays 1 and `addr_out`, `busy` and `row_done` stay 0.
